// File: rtl/coreahbtoapb3_apb_phase_sequencer_if.sv
// ---------------------------------------------------------------------------
// coreahbtoapb3_apb_phase_sequencer_if : control + APB3 bus bundle. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface coreahbtoapb3_apb_phase_sequencer_if #(
  parameter int NUM_SLAVES = 16,
  parameter int SEL_W      = 4
);
  logic                  start;
  logic [SEL_W-1:0]      slaveSel;
  logic                  abort;
  logic [NUM_SLAVES-1:0] PREADYS;
  logic [NUM_SLAVES-1:0] PSLVERRS;
  logic [NUM_SLAVES-1:0] PSELS;
  logic                  PENABLE;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic                  timedOut;

  // The sequencer is the APB master; the environment (AHB FSM + slaves) is the slave side.
  modport master (
    input  start, slaveSel, abort, PREADYS, PSLVERRS,
    output PSELS, PENABLE, busy, done, err, timedOut
  );

  modport slave (
    output start, slaveSel, abort, PREADYS, PSLVERRS,
    input  PSELS, PENABLE, busy, done, err, timedOut
  );
endinterface

`default_nettype wire

// File: rtl/coreahbtoapb3_apb_phase_sequencer.sv
// ---------------------------------------------------------------------------
// coreahbtoapb3_apb_phase_sequencer : multi-slave APB3 SETUP/ACCESS engine. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module coreahbtoapb3_apb_phase_sequencer #(
  parameter int NUM_SLAVES = 16,
  parameter int SEL_W      = 4,
  parameter int SETUP_WAIT = 0,
  parameter int TIMEOUT    = 0,
  parameter int TO_W       = 16
) (
  input wire HCLK,
  input wire HRESETN,
  coreahbtoapb3_apb_phase_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_BADSEL = 2'd3
  } state_t;

  localparam logic [SEL_W:0]  c_NUM_SLAVES = (SEL_W+1)'(NUM_SLAVES);
  localparam logic [2:0]      c_SETUP_LAST = 3'(SETUP_WAIT);
  localparam logic [TO_W-1:0] c_TO_LAST    = TO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [TO_W-1:0] c_TO_MAX     = {TO_W{1'b1}};
  localparam bit              c_TO_EN      = (TIMEOUT != 0);

  state_t                r_state,     w_state_nxt;
  logic [SEL_W-1:0]      r_idx,       w_idx_nxt;
  logic [2:0]            r_setup_cnt, w_setup_cnt_nxt;
  logic [TO_W-1:0]       r_to_cnt,    w_to_cnt_nxt;
  logic [NUM_SLAVES-1:0] r_psels,     w_psels_nxt;
  logic                  r_penable,   w_penable_nxt;
  logic                  r_done,      w_done_nxt;
  logic                  r_err,       w_err_nxt;
  logic                  r_timedout,  w_timedout_nxt;

  logic                  w_sel_ready;
  logic                  w_sel_slverr;
  logic [NUM_SLAVES-1:0] w_onehot_nxt;

  // Only the latched slave's handshake is ever observed.
  always_comb begin
    w_sel_ready  = 1'b0;
    w_sel_slverr = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_idx == SEL_W'(i)) begin
        w_sel_ready  = bus.PREADYS[i];
        w_sel_slverr = bus.PSLVERRS[i];
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_setup_cnt_nxt = r_setup_cnt;
    w_to_cnt_nxt    = r_to_cnt;
    w_done_nxt      = 1'b0;
    w_err_nxt       = 1'b0;
    w_timedout_nxt  = 1'b0;
    w_onehot_nxt    = '0;
    w_psels_nxt     = '0;
    w_penable_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if ({1'b0, bus.slaveSel} < c_NUM_SLAVES) begin
            w_idx_nxt   = bus.slaveSel;
            w_state_nxt = S_SETUP;
          end else begin
            w_state_nxt = S_BADSEL;
          end
        end
      end
      S_SETUP: begin
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
          w_err_nxt   = 1'b1;
        end else if (r_setup_cnt == c_SETUP_LAST) begin
          w_state_nxt = S_ACCESS;
        end else begin
          w_setup_cnt_nxt = r_setup_cnt + 3'd1;
        end
      end
      S_ACCESS: begin
        // Completion beats abort, which beats timeout.
        if (w_sel_ready) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
          w_err_nxt   = w_sel_slverr;
        end else if (bus.abort) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
          w_err_nxt   = 1'b1;
        end else if (c_TO_EN && (r_to_cnt == c_TO_LAST)) begin
          w_state_nxt    = S_IDLE;
          w_done_nxt     = 1'b1;
          w_err_nxt      = 1'b1;
          w_timedout_nxt = 1'b1;
        end else if (r_to_cnt != c_TO_MAX) begin
          w_to_cnt_nxt = r_to_cnt + TO_W'(1);
        end
      end
      S_BADSEL: begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b1;
        w_err_nxt   = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_state_nxt == S_IDLE) begin
      w_setup_cnt_nxt = '0;
      w_to_cnt_nxt    = '0;
    end

    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (w_idx_nxt == SEL_W'(i)) begin
        w_onehot_nxt[i] = 1'b1;
      end
    end

    if ((w_state_nxt == S_SETUP) || (w_state_nxt == S_ACCESS)) begin
      w_psels_nxt = w_onehot_nxt;
    end
    w_penable_nxt = (w_state_nxt == S_ACCESS);
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_setup_cnt <= '0;
      r_to_cnt    <= '0;
      r_psels     <= '0;
      r_penable   <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_timedout  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_setup_cnt <= w_setup_cnt_nxt;
      r_to_cnt    <= w_to_cnt_nxt;
      r_psels     <= w_psels_nxt;
      r_penable   <= w_penable_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_timedout  <= w_timedout_nxt;
    end
  end

  assign bus.PSELS    = r_psels;
  assign bus.PENABLE  = r_penable;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = r_done;
  assign bus.err      = r_err;
  assign bus.timedOut = r_timedout;

endmodule

`default_nettype wire

// File: tb/tb_coreahbtoapb3_apb_phase_sequencer.sv
// ---------------------------------------------------------------------------
// tb_coreahbtoapb3_apb_phase_sequencer : randomized bench with a transfer-level model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_coreahbtoapb3_apb_phase_sequencer;

  logic HCLK = 1'b0;
  logic HRESETN;
  always #5 HCLK = ~HCLK;

  // Instance A: no extra setup, no timeout.  Instance B: 2 extra setup cycles, timeout of 5.
  coreahbtoapb3_apb_phase_sequencer_if #(.NUM_SLAVES(4), .SEL_W(3)) if_a ();
  coreahbtoapb3_apb_phase_sequencer_if #(.NUM_SLAVES(4), .SEL_W(3)) if_b ();

  coreahbtoapb3_apb_phase_sequencer #(
    .NUM_SLAVES(4), .SEL_W(3), .SETUP_WAIT(0), .TIMEOUT(0), .TO_W(16)
  ) dut_a (
    .HCLK(HCLK), .HRESETN(HRESETN), .bus(if_a)
  );

  coreahbtoapb3_apb_phase_sequencer #(
    .NUM_SLAVES(4), .SEL_W(3), .SETUP_WAIT(2), .TIMEOUT(5), .TO_W(8)
  ) dut_b (
    .HCLK(HCLK), .HRESETN(HRESETN), .bus(if_b)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic drive_in(input bit which, input logic st, input logic [2:0] sel,
                          input logic ab, input logic [3:0] rdy, input logic [3:0] se);
    if (!which) begin
      if_a.start = st; if_a.slaveSel = sel; if_a.abort = ab;
      if_a.PREADYS = rdy; if_a.PSLVERRS = se;
    end else begin
      if_b.start = st; if_b.slaveSel = sel; if_b.abort = ab;
      if_b.PREADYS = rdy; if_b.PSLVERRS = se;
    end
  endtask

  // {PSELS, PENABLE, busy, done, err, timedOut}
  task automatic get_out(input bit which, output logic [8:0] o);
    if (!which)
      o = {if_a.PSELS, if_a.PENABLE, if_a.busy, if_a.done, if_a.err, if_a.timedOut};
    else
      o = {if_b.PSELS, if_b.PENABLE, if_b.busy, if_b.done, if_b.err, if_b.timedOut};
  endtask

  // One transfer: the model works out the cycle the transfer ends (relative to start)
  // and the outcome, then every cycle is checked against the expected bus picture.
  // Cycle k = k-th cycle after the one in which start was presented.
  task automatic run_xfer(input bit which, input string tag, input int sel,
                          input int ready_at, input bit slverr, input int abort_at,
                          input bit chained, input bit chain_next, input int next_sel,
                          input bit noise);
    int   sw, to, k_a, e, outcome, last, j;
    bit   bad;
    logic [8:0] got, exp;
    logic [3:0] rdy, se, exp_psel;
    logic       st, ab, exp_done, exp_err, exp_to;
    logic [2:0] drv_sel;
    sw  = which ? 2 : 0;
    to  = which ? 5 : 0;
    k_a = 2 + sw;
    e   = 0;
    outcome = 0;
    bad = (sel >= 4);
    if (bad) begin
      e = 1;
      outcome = 3;
    end else begin
      for (int k = 1; k <= 200 && e == 0; k++) begin
        if (k < k_a) begin
          if (abort_at == k) begin e = k; outcome = 1; end
        end else begin
          j = k - k_a + 1;
          if (ready_at == j)              begin e = k; outcome = 0; end
          else if (abort_at == k)         begin e = k; outcome = 1; end
          else if (to != 0 && j == to)    begin e = k; outcome = 2; end
        end
      end
    end
    if (e == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL %s model: transfer never ends (ready_at=%0d)", tag, ready_at);
      return;
    end

    if (!chained) begin
      @(negedge HCLK);
      drive_in(which, 1'b1, 3'(sel), 1'b0, 4'($urandom), 4'($urandom));
    end

    last = chain_next ? e + 1 : e + 2;
    for (int k = 1; k <= last; k++) begin
      @(negedge HCLK);
      exp_psel = (!bad && k <= e) ? (4'b0001 << sel) : 4'b0000;
      exp_done = (k == e + 1);
      exp_err  = exp_done && ((outcome == 0) ? slverr : 1'b1);
      exp_to   = exp_done && (outcome == 2);
      exp = {exp_psel, (!bad && k >= k_a && k <= e), (k <= e), exp_done, exp_err, exp_to};
      get_out(which, got);
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got psel=%b pen=%b busy=%b done=%b err=%b to=%b, expected psel=%b pen=%b busy=%b done=%b err=%b to=%b",
                 tag, k, got[8:5], got[4], got[3], got[2], got[1], got[0],
                 exp[8:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
      end

      rdy = 4'($urandom);
      se  = 4'($urandom);
      if (!bad && k >= k_a && k <= e) begin
        rdy[sel] = ((k - k_a + 1) == ready_at);
        se[sel]  = slverr;
      end
      drv_sel = 3'($urandom);
      if (k <= e) begin
        st = noise ? 1'($urandom) : 1'b0;
        ab = (k == abort_at);
      end else if (k == e + 1 && chain_next) begin
        st = 1'b1;
        drv_sel = 3'(next_sel);
        ab = noise ? 1'($urandom) : 1'b0;
      end else begin
        st = 1'b0;
        ab = noise ? 1'($urandom) : 1'b0;
      end
      drive_in(which, st, drv_sel, ab, rdy, se);
    end
  endtask

  task automatic test_reset();
    logic [8:0] got;
    HRESETN = 1'b0;
    drive_in(1'b0, 1'b0, 3'd0, 1'b0, 4'hF, 4'hF);
    drive_in(1'b1, 1'b0, 3'd0, 1'b0, 4'hF, 4'hF);
    repeat (2) @(negedge HCLK);
    for (int w = 0; w < 2; w++) begin
      get_out(w[0], got);
      n_cmp++;
      if (got !== 9'd0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: got %b expected %b", w, got, 9'd0);
      end
    end
    HRESETN = 1'b1;
    @(negedge HCLK);
    for (int w = 0; w < 2; w++) begin
      get_out(w[0], got);
      n_cmp++;
      if (got !== 9'd0) begin
        n_fail++;
        $display("FAIL idle_after_reset dut%0d: got %b expected %b", w, got, 9'd0);
      end
    end
  endtask

  task automatic test_min_latency();
    run_xfer(1'b0, "min_latency", 2, 1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_setup_wait();
    run_xfer(1'b1, "setup_wait_slverr", 1, 4, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_timeout();
    run_xfer(1'b1, "timeout_expire", 3, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    run_xfer(1'b1, "timeout_ready_last", 3, 5, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_bad_index();
    run_xfer(1'b0, "bad_index", 7, 1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
    run_xfer(1'b1, "bad_index_b", 4, 1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_xfer(1'b0, "b2b_first", 0, 1, 1'b0, 0, 1'b0, 1'b1, 3, 1'b0);
    run_xfer(1'b0, "b2b_second", 3, 2, 1'b0, 0, 1'b1, 1'b0, 0, 1'b1);
  endtask

  task automatic test_abort();
    run_xfer(1'b1, "abort_access2", 2, 0, 1'b0, 5, 1'b0, 1'b0, 0, 1'b0);
    run_xfer(1'b0, "abort_setup", 1, 3, 1'b0, 1, 1'b0, 1'b0, 0, 1'b0);
    run_xfer(1'b0, "abort_vs_ready", 0, 2, 1'b1, 3, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_reset_mid_transfer();
    logic [8:0] got;
    @(negedge HCLK);
    drive_in(1'b1, 1'b1, 3'd1, 1'b0, 4'b0000, 4'b0000);
    for (int k = 1; k <= 5; k++) begin
      @(negedge HCLK);
      drive_in(1'b1, 1'b0, 3'd1, 1'b0, 4'b0000, 4'b0000);
    end
    get_out(1'b1, got);
    n_cmp++;
    if (got !== 9'b0010_1_1_0_0_0) begin
      n_fail++;
      $display("FAIL pre_reset_access: got %b expected %b", got, 9'b0010_1_1_0_0_0);
    end
    #2 HRESETN = 1'b0;
    #1 get_out(1'b1, got);
    n_cmp++;
    if (got !== 9'd0) begin
      n_fail++;
      $display("FAIL async_reset_drop: got %b expected %b", got, 9'd0);
    end
    @(negedge HCLK);
    HRESETN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge HCLK);
      get_out(1'b1, got);
      n_cmp++;
      if (got !== 9'd0) begin
        n_fail++;
        $display("FAIL no_done_after_reset cycle %0d: got %b expected %b", k, got, 9'd0);
      end
    end
  endtask

  task automatic test_random();
    int sel, ready_at, abort_at, sw, k_a;
    bit which, se;
    string tag;
    for (int n = 0; n < 40; n++) begin
      which    = n[0];
      sw       = which ? 2 : 0;
      k_a      = 2 + sw;
      sel      = int'($urandom_range(0, 5));
      ready_at = which ? int'($urandom_range(0, 7)) : int'($urandom_range(1, 6));
      se       = 1'($urandom);
      abort_at = 0;
      if ($urandom_range(0, 3) == 0)
        abort_at = int'($urandom_range(1, 1 + sw + ((ready_at == 0) ? 5 : ready_at)));
      if (which && abort_at == k_a + 4)
        abort_at = 0;
      tag = $sformatf("random%0d", n);
      run_xfer(which, tag, sel, ready_at, se, abort_at, 1'b0, 1'b0, 0, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_min_latency();
    test_setup_wait();
    test_timeout();
    test_bad_index();
    test_back_to_back();
    test_abort();
    test_reset_mid_transfer();
    test_random();
    repeat (2) @(negedge HCLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
